// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Runs the request-to-send handshake (clock inhibit, then start bit) and
// shifts a command frame out on the falling edges of the device clock.
// It then checks the device acknowledge bit. A NACK or a timeout causes
// the same frame to be re-sent, up to MAX_RETRIES times, before error is
// reported. Both PS/2 lines are open-drain: they are pulled low or
// released, and never driven high.
module ps2_host_tx #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_ODD     = 1,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                 slowClk,
  input  logic                 reset,
  inout  wire                  psclk,
  inout  wire                  psdata,
  input  logic [DATA_BITS-1:0] command,
  input  logic                 send,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int FW   = DATA_BITS + 3;
  localparam int IW   = $clog2(FW);
  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic          ODD      = (PARITY_ODD != 0);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] STOP_IDX = IW'(FW - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, FAIL
  } state_t;

  state_t          state_r;
  logic [FW-1:0]   frame_r;
  logic [IW-1:0]   bit_idx_r;
  logic [CW-1:0]   cnt_r;
  logic [RW-1:0]   retry_r;
  logic            clk_low_r;
  logic            data_low_r;
  logic            busy_r;
  logic            done_r;
  logic            error_r;
  logic [2:0]      clk_sync_r;   // [0] first stage, [1] synchronised, [2] previous
  logic [1:0]      data_sync_r;  // [1] synchronised

  logic            clk_fall_s;
  logic            tmo_hit_s;
  logic            lines_high_s;

  // Parity bit over the payload; odd parity inverts the plain XOR.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (^d) ^ ODD;
  endfunction

  assign psclk  = clk_low_r  ? 1'b0 : 1'bz;
  assign psdata = data_low_r ? 1'b0 : 1'bz;

  assign busy  = busy_r;
  assign done  = done_r;
  assign error = error_r;

  assign clk_fall_s   = clk_sync_r[2] & ~clk_sync_r[1];
  assign tmo_hit_s    = (cnt_r == TMO_LAST);
  assign lines_high_s = clk_sync_r[1] & data_sync_r[1];

  // Synchronise both pins into the slowClk domain; idle lines read as high.
  always_ff @(posedge slowClk) begin
    if (reset) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], psclk};
      data_sync_r <= {data_sync_r[0], psdata};
    end
  end

  // Transmit sequencer: inhibit, request, shift, acknowledge, retry.
  always_ff @(posedge slowClk) begin
    if (reset) begin
      state_r    <= IDLE;
      frame_r    <= '0;
      bit_idx_r  <= '0;
      cnt_r      <= '0;
      retry_r    <= '0;
      clk_low_r  <= 1'b0;
      data_low_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_low_r  <= 1'b0;
          data_low_r <= 1'b0;
          if (send) begin
            frame_r   <= {1'b1, parity_of(command), command, 1'b0};
            retry_r   <= '0;
            cnt_r     <= '0;
            clk_low_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= INHIBIT;
          end else begin
            busy_r <= 1'b0;
          end
        end
        INHIBIT: begin
          if (cnt_r == INH_LAST) begin
            // The start bit goes out as the clock is released.
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b1;
            cnt_r      <= '0;
            state_r    <= REQ;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        REQ: begin
          cnt_r     <= '0;
          bit_idx_r <= IW'(1);
          state_r   <= SHIFT;
        end
        SHIFT: begin
          if (clk_fall_s) begin
            cnt_r      <= '0;
            data_low_r <= ~frame_r[bit_idx_r];
            if (bit_idx_r == STOP_IDX) begin
              state_r <= ACK;
            end else begin
              bit_idx_r <= bit_idx_r + IW'(1);
            end
          end else if (tmo_hit_s) begin
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
            state_r    <= FAIL;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ACK: begin
          data_low_r <= 1'b0;
          if (clk_fall_s) begin
            cnt_r   <= '0;
            state_r <= data_sync_r[1] ? FAIL : WAIT_IDLE;
          end else if (tmo_hit_s) begin
            clk_low_r <= 1'b0;
            state_r   <= FAIL;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (lines_high_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (tmo_hit_s) begin
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
            state_r    <= FAIL;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        FAIL: begin
          data_low_r <= 1'b0;
          cnt_r      <= '0;
          if (retry_r < RETRY_MAX) begin
            retry_r   <= retry_r + RW'(1);
            clk_low_r <= 1'b1;
            state_r   <= INHIBIT;
          end else begin
            clk_low_r <= 1'b0;
            error_r   <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          clk_low_r  <= 1'b0;
          data_low_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx. Two hosts, with odd and with even parity,
// share one pulled-up open-drain PS/2 bus with a behavioural device.
// Expected frames and done/error events are queued when stimulus is
// issued and are popped by the device capture and the output monitor.
module tb_ps2_host_tx;

  localparam int HALF = 40;
  localparam int TMO  = 2000;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [10:0] val;
  } ev_t;

  logic       slowClk;
  logic       reset;
  logic [7:0] command, command_e;
  logic       send, send_e;
  logic       busy, done, error;
  logic       busy_e, done_e, error_e;
  wire        psclk, psdata;
  logic       dev_clk_low, dev_data_low;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  dev_rts = 0;
  int  dev_falls = 0;
  int  dev_nacks = 0;
  bit  dev_enable = 1'b1;
  bit  dev_abort = 1'b0;

  pullup (psclk);
  pullup (psdata);
  assign psclk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign psdata = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.PARITY_ODD(1), .TIMEOUT_CYCLES(TMO)) u_odd (
    .slowClk(slowClk), .reset(reset), .psclk(psclk), .psdata(psdata),
    .command(command), .send(send), .busy(busy), .done(done), .error(error)
  );

  ps2_host_tx #(.PARITY_ODD(0), .TIMEOUT_CYCLES(TMO)) u_even (
    .slowClk(slowClk), .reset(reset), .psclk(psclk), .psdata(psdata),
    .command(command_e), .send(send_e), .busy(busy_e), .done(done_e), .error(error_e)
  );

  initial slowClk = 1'b0;
  always #5 slowClk = ~slowClk;

  function automatic void check_event(input logic [1:0] kind, input logic [10:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%h, required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        errors++;
        $display("FAIL scoreboard: got kind=%0d val=%h, required kind=%0d val=%h",
                 kind, val, e.kind, e.val);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [10:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Output monitor: every done/error pulse is matched against the queue.
  always @(negedge slowClk) begin
    if (done === 1'b1)    check_event(K_DONE, 11'd0);
    if (done_e === 1'b1)  check_event(K_DONE, 11'd1);
    if (error === 1'b1)   check_event(K_ERR, 11'd0);
    if (error_e === 1'b1) check_event(K_ERR, 11'd1);
    if ((done === 1'b1 && error === 1'b1) || (done_e === 1'b1 && error_e === 1'b1)) begin
      errors++;
      $display("FAIL done_and_error: got both high, required at most one");
    end
  end

  task automatic dev_wait(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge slowClk);
      if (dev_abort) return;
    end
  endtask

  // One device-clocked frame: sample 11 bits on the high phases, then ACK or NACK.
  task automatic run_frame();
    logic [10:0] bits;
    bit ack;
    bits = 11'd0;
    ack = (dev_nacks == 0);
    if (!ack) dev_nacks = dev_nacks - 1;
    dev_wait(20);
    for (int i = 0; i < 11; i++) begin
      if (dev_abort) break;
      dev_wait(HALF / 2);
      if (dev_abort) break;
      bits[i] = (psdata === 1'b1);
      if (i == 10) begin
        check_event(K_FRAME, bits);
        if (ack) dev_data_low = 1'b1;
      end
      dev_wait(HALF / 2);
      if (dev_abort) break;
      dev_clk_low = 1'b1;
      dev_falls++;
      dev_wait(HALF);
      dev_clk_low = 1'b0;
    end
    dev_wait(2);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  // Device: answers each request-to-send, or ignores it when disabled.
  initial begin : device
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge slowClk);
      if (psclk === 1'b1 && psdata === 1'b0 && reset === 1'b0) begin
        dev_rts++;
        dev_falls = 0;
        if (dev_enable) begin
          run_frame();
        end else begin
          while (psdata === 1'b0) @(negedge slowClk);
        end
      end
    end
  end

  task automatic do_send(input bit inst, input logic [7:0] cmd);
    @(negedge slowClk);
    if (inst) begin
      command_e = cmd;
      send_e = 1'b1;
    end else begin
      command = cmd;
      send = 1'b1;
    end
    @(negedge slowClk);
    send   = 1'b0;
    send_e = 1'b0;
    chk("busy_after_accept", inst ? busy_e : busy, 32'd1);
  endtask

  task automatic wait_not_busy(input bit inst, input int budget, output int cycles);
    cycles = 0;
    while ((inst ? busy_e : busy) === 1'b1 && cycles < budget) begin
      @(negedge slowClk);
      cycles++;
    end
    chk("busy_released", inst ? busy_e : busy, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    int cyc;
    int lowcnt;
    int rts0;
    reset = 1'b1;
    send = 1'b0;
    send_e = 1'b0;
    command = 8'h00;
    command_e = 8'h00;
    repeat (3) @(negedge slowClk);
    reset = 1'b0;
    @(negedge slowClk);
    chk("reset_busy", busy, 32'd0);
    chk("reset_done", done, 32'd0);
    chk("reset_error", error, 32'd0);
    chk("reset_busy_even", busy_e, 32'd0);
    chk("reset_psclk", psclk, 32'd1);
    chk("reset_psdata", psdata, 32'd1);

    // F4, odd parity: inhibit length measured before the start bit.
    push(K_FRAME, 11'h5E8);
    push(K_DONE, 11'd0);
    do_send(1'b0, 8'hF4);
    lowcnt = 0;
    for (int k = 0; k < 6000 && psdata !== 1'b0; k++) begin
      if (psclk === 1'b0) lowcnt++;
      @(negedge slowClk);
    end
    chk("inhibit_len", lowcnt, 32'd5000);
    chk("req_clk_released", psclk, 32'd1);
    wait_not_busy(1'b0, 8000, cyc);
    @(negedge slowClk);
    chk("queue_f4", exp_q.size(), 32'd0);

    // FF, odd parity -> parity 1; a send while busy and command change are ignored.
    push(K_FRAME, 11'h7FE);
    push(K_DONE, 11'd0);
    do_send(1'b0, 8'hFF);
    command = 8'h00;
    repeat (10) @(negedge slowClk);
    send = 1'b1;
    @(negedge slowClk);
    send = 1'b0;
    wait_not_busy(1'b0, 8000, cyc);
    @(negedge slowClk);
    chk("queue_ff", exp_q.size(), 32'd0);

    // ED, even parity -> parity 0.
    push(K_FRAME, 11'h5DA);
    push(K_DONE, 11'd1);
    do_send(1'b1, 8'hED);
    wait_not_busy(1'b1, 8000, cyc);
    @(negedge slowClk);
    chk("queue_ed", exp_q.size(), 32'd0);

    // NACK on the first attempt, ACK on the retry.
    dev_nacks = 1;
    rts0 = dev_rts;
    push(K_FRAME, 11'h624);
    push(K_FRAME, 11'h624);
    push(K_DONE, 11'd0);
    do_send(1'b0, 8'h12);
    wait_not_busy(1'b0, 15000, cyc);
    @(negedge slowClk);
    chk("nack_attempts", dev_rts - rts0, 32'd2);
    chk("queue_nack", exp_q.size(), 32'd0);

    // The device never clocks: three timed-out attempts, then one error.
    dev_enable = 1'b0;
    rts0 = dev_rts;
    push(K_ERR, 11'd0);
    do_send(1'b0, 8'h55);
    wait_not_busy(1'b0, 30000, cyc);
    chk("timeout_total", (cyc >= 21000 && cyc <= 21040) ? 32'd1 : 32'd0, 32'd1);
    @(negedge slowClk);
    chk("timeout_attempts", dev_rts - rts0, 32'd3);
    chk("err_psclk", psclk, 32'd1);
    chk("err_psdata", psdata, 32'd1);
    chk("queue_timeout", exp_q.size(), 32'd0);
    dev_enable = 1'b1;

    // Reset after five data edges: lines released and nothing is reported.
    do_send(1'b0, 8'h3C);
    cyc = 0;
    while (dev_falls < 5 && cyc < 8000) begin
      @(negedge slowClk);
      cyc++;
    end
    chk("reached_5_edges", (dev_falls >= 5) ? 32'd1 : 32'd0, 32'd1);
    cyc = 0;
    while (psclk !== 1'b1 && cyc < 200) begin
      @(negedge slowClk);
      cyc++;
    end
    repeat (5) @(negedge slowClk);
    dev_abort = 1'b1;
    reset = 1'b1;
    @(negedge slowClk);
    reset = 1'b0;
    @(negedge slowClk);
    chk("midreset_psclk", psclk, 32'd1);
    chk("midreset_psdata", psdata, 32'd1);
    chk("midreset_busy", busy, 32'd0);
    repeat (100) @(negedge slowClk);
    dev_abort = 1'b0;
    chk("queue_midreset", exp_q.size(), 32'd0);

    // AA, odd parity -> parity 1, sent normally after the reset.
    push(K_FRAME, 11'h754);
    push(K_DONE, 11'd0);
    do_send(1'b0, 8'hAA);
    wait_not_busy(1'b0, 8000, cyc);
    repeat (2) @(negedge slowClk);
    chk("queue_final", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
